modinv_helper_extend: RTL and testbench

Modular-inverter helper that copies an OPERAND_NUM_WORDS-word operand from operand memory "a" into the wider working buffer "s". It zero-fills the extra top buffer words. While the words stream past, it also classifies the operand as zero or as one. It mirrors the buffer-to-operand copy helper: the two are the load and store ends of the same operand/buffer path, and share the same word-serial, counter-sequenced protocol.

---
 rtl/modinv_helper_extend.sv | 89 ++++++++
 tb/tb_modinv_helper_extend.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_helper_extend.sv
// Copies the operand from memory "a" into buffer "s", zero-fills the extra buffer words, and flags operand==0 / operand==1.
// Latency: rdy is low for BUFFER_NUM_WORDS+1 cycles after the start edge. No backpressure: writes stream unconditionally and ena is ignored while busy.
module modinv_helper_extend #(
    parameter int OPERAND_NUM_WORDS = 8,
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int BUFFER_NUM_WORDS  = 9,
    parameter int BUFFER_ADDR_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    output logic                         rdy,
    output logic [OPERAND_ADDR_BITS-1:0] a_addr,
    input  logic [31:0]                  a_din,
    output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
    output logic                         s_wren,
    output logic [31:0]                  s_dout,
    output logic                         a_is_zero,
    output logic                         a_is_one
);

    localparam int CNT_W = $clog2(BUFFER_NUM_WORDS + 2);

    localparam logic [CNT_W-1:0]             CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]             CNT_RD_LAST  = CNT_W'(OPERAND_NUM_WORDS);
    localparam logic [CNT_W-1:0]             CNT_WR_FIRST = CNT_W'(2);
    localparam logic [CNT_W-1:0]             CNT_LAST     = CNT_W'(BUFFER_NUM_WORDS + 1);
    localparam logic [OPERAND_ADDR_BITS-1:0] A_LAST       = OPERAND_ADDR_BITS'(OPERAND_NUM_WORDS - 1);
    localparam logic [OPERAND_ADDR_BITS-1:0] A_ONE        = OPERAND_ADDR_BITS'(1);
    localparam logic [BUFFER_ADDR_BITS-1:0]  S_LAST       = BUFFER_ADDR_BITS'(BUFFER_NUM_WORDS - 1);
    localparam logic [BUFFER_ADDR_BITS-1:0]  S_ONE        = BUFFER_ADDR_BITS'(1);
    localparam logic [BUFFER_ADDR_BITS-1:0]  S_OPND_END   = BUFFER_ADDR_BITS'(OPERAND_NUM_WORDS);

    logic [CNT_W-1:0] proc_cnt;
    logic             rd_phase;
    logic             wr_phase;
    logic             s_in_opnd;
    logic [31:0]      one_word;

    assign rdy       = (proc_cnt == '0);
    assign rd_phase  = !rdy && (proc_cnt <= CNT_RD_LAST);
    assign wr_phase  = (proc_cnt >= CNT_WR_FIRST) && (proc_cnt <= CNT_LAST);
    assign s_in_opnd = (s_addr < S_OPND_END);
    assign s_wren    = wr_phase;
    assign s_dout    = s_in_opnd ? a_din : 32'h0;
    // The value "one" has 1 in the least significant word and 0 everywhere else.
    assign one_word  = {31'd0, (s_addr == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_cnt  <= '0;
            a_addr    <= '0;
            s_addr    <= '0;
            a_is_zero <= 1'b0;
            a_is_one  <= 1'b0;
        end else begin
            if (rdy) begin
                if (ena) begin
                    proc_cnt  <= CNT_ONE;
                    a_is_zero <= 1'b1;
                    a_is_one  <= 1'b1;
                end
            end else if (proc_cnt == CNT_LAST) begin
                proc_cnt <= '0;
            end else begin
                proc_cnt <= proc_cnt + CNT_ONE;
            end

            if (rd_phase)
                a_addr <= (a_addr == A_LAST) ? '0 : a_addr + A_ONE;
            else
                a_addr <= '0;

            if (wr_phase)
                s_addr <= (s_addr == S_LAST) ? '0 : s_addr + S_ONE;
            else
                s_addr <= '0;

            // Zero-fill words carry no operand information, so they leave the flags alone.
            if (wr_phase && s_in_opnd) begin
                if (a_din != 32'h0)
                    a_is_zero <= 1'b0;
                if (a_din != one_word)
                    a_is_one <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modinv_helper_extend.sv
// Randomized and directed bench for modinv_helper_extend against a word-array reference model.
module tb_modinv_helper_extend;

    localparam int OP_N  = 8;
    localparam int BUF_N = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        rdy;
    logic [2:0]  a_addr;
    logic [31:0] a_din = 32'h0;
    logic [3:0]  s_addr;
    logic        s_wren;
    logic [31:0] s_dout;
    logic        a_is_zero;
    logic        a_is_one;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [OP_N];
    logic [31:0] wbuf [BUF_N];
    int          wr_cnt = 0;
    logic [2:0]  addr_q = 3'd0;

    modinv_helper_extend #(
        .OPERAND_NUM_WORDS(OP_N),
        .OPERAND_ADDR_BITS(3),
        .BUFFER_NUM_WORDS(BUF_N),
        .BUFFER_ADDR_BITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .rdy(rdy),
        .a_addr(a_addr),
        .a_din(a_din),
        .s_addr(s_addr),
        .s_wren(s_wren),
        .s_dout(s_dout),
        .a_is_zero(a_is_zero),
        .a_is_one(a_is_one)
    );

    always #5 clk = ~clk;

    // Synchronous operand RAM: address seen before the edge, data shortly after it.
    always @(negedge clk) addr_q = a_addr;
    always @(posedge clk) begin
        #1 a_din = mem[addr_q];
    end

    // Buffer memory model capturing every write.
    always @(negedge clk) begin
        if (s_wren) begin
            if (s_addr < 4'(BUF_N))
                wbuf[s_addr] = s_dout;
            wr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_wbuf();
        for (int j = 0; j < BUF_N; j++) wbuf[j] = 32'hDEADBEEF;
        wr_cnt = 0;
    endtask

    // Expected result: buffer is the operand followed by zeros; flags describe the operand's integer value.
    task automatic check_results(input string tag);
        logic [31:0] exp_w;
        bit          any_nonzero;
        bit          upper_nonzero;
        any_nonzero   = 0;
        upper_nonzero = 0;
        for (int k = 0; k < OP_N; k++) begin
            if (mem[k] != 0) any_nonzero = 1;
            if (k > 0 && mem[k] != 0) upper_nonzero = 1;
        end
        check({tag, "_wr_cnt"}, wr_cnt, BUF_N);
        for (int j = 0; j < BUF_N; j++) begin
            exp_w = (j < OP_N) ? mem[j] : 32'h0;
            check($sformatf("%s_s%0d", tag, j), wbuf[j], exp_w);
        end
        check({tag, "_rdy"}, rdy, 1);
        check({tag, "_is_zero"}, a_is_zero, !any_nonzero);
        check({tag, "_is_one"}, a_is_one, (mem[0] == 32'd1) && !upper_nonzero);
    endtask

    // Called at the negedge right after the start edge; returns at the first negedge with rdy=1.
    task automatic busy_phase(input string tag, input bit mid_pulse);
        int c;
        c = 1;
        while (!rdy && c <= 40) begin
            check({tag, "_wren"}, s_wren, (c >= 2) && (c <= BUF_N + 1));
            if (c <= OP_N) check({tag, "_a_addr"}, a_addr, c - 1);
            if (mid_pulse && c == 4) ena = 1'b1;
            if (mid_pulse && c == 6) ena = 1'b0;
            @(negedge clk);
            c++;
        end
        check({tag, "_busy_len"}, c - 1, BUF_N + 1);
    endtask

    task automatic do_run(input string tag, input bit mid_pulse);
        clear_wbuf();
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        busy_phase(tag, mid_pulse);
        check_results(tag);
        if (mid_pulse) begin
            repeat (3) begin
                @(negedge clk);
                check({tag, "_no_queue"}, rdy, 1);
            end
        end
    endtask

    task automatic load_pattern(input int kind);
        for (int k = 0; k < OP_N; k++) begin
            case (kind)
                0: mem[k] = 32'h11111111 * (k + 1);
                1: mem[k] = 32'h0;
                2: mem[k] = (k == 0) ? 32'd1 : 32'd0;
                3: mem[k] = (k == 0) ? 32'd1 : ((k == OP_N - 1) ? 32'h80000000 : 32'd0);
                4: mem[k] = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
                default: mem[k] = (k == 0) ? $urandom_range(0, 2) : (($urandom_range(0, 5) == 0) ? 32'h1 : 32'h0);
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < OP_N; k++) mem[k] = 32'h0;
        clear_wbuf();
        #12 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            check("idle_rdy", rdy, 1);
            check("idle_wren", s_wren, 0);
            check("idle_a_addr", a_addr, 0);
            check("idle_s_addr", s_addr, 0);
            check("idle_flags", {a_is_zero, a_is_one}, 0);
            @(negedge clk);
        end

        load_pattern(0); do_run("incr", 1'b0);
        load_pattern(1); do_run("zero", 1'b0);
        load_pattern(2); do_run("one", 1'b0);
        load_pattern(3); do_run("one_top", 1'b0);
        load_pattern(0); do_run("drop_pulse", 1'b1);
        for (int r = 0; r < 6; r++) begin
            load_pattern(4 + (r % 2));
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        // ena held high: back-to-back runs separated by exactly one idle cycle.
        ena = 1'b1;
        load_pattern(4);
        clear_wbuf();
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            busy_phase($sformatf("b2b%0d", r), 1'b0);
            check_results($sformatf("b2b%0d", r));
            if (r < 2) begin
                load_pattern(4 + r);
                clear_wbuf();
                @(negedge clk);
                check($sformatf("b2b%0d_restart", r), rdy, 0);
            end else begin
                ena = 1'b0;
                @(negedge clk);
                check("b2b_stop", rdy, 1);
            end
        end

        // Reset in the middle of a run.
        load_pattern(0);
        clear_wbuf();
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_wren", s_wren, 0);
        check("rst_flags", {a_is_zero, a_is_one}, 0);
        check("rst_addr", {a_addr, s_addr}, 0);
        begin
            int snap;
            snap = wr_cnt;
            @(negedge clk);
            @(negedge clk);
            check("rst_no_writes", wr_cnt, snap);
        end
        rst_n = 1'b1;
        @(negedge clk);
        load_pattern(2);
        do_run("after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
